queue_reduce_sequencer: RTL and testbench

Controller stage directly upstream of the 5-entry calculator queue. It accepts an operand stream over a valid/ready handshake and pushes operands into the queue. It reads the queue's front pair, computes the ALU result and issues combine-and-push until one value remains, then pops that value out over a valid/ready result port. It owns the queue's opcode/back inputs and keeps its own occupancy count, because the queue exposes only is_empty.

---
 rtl/queue_reduce_sequencer.sv | 157 +++++++++++++++
 tb/tb_queue_reduce_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_reduce_sequencer.sv
// queue_reduce_sequencer: drives a 5-entry calculator queue. It pushes an
// operand stream, reduces the front pair until one value remains, then pops
// that value out over a valid/ready result port.
module queue_reduce_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               err,
  output logic [1:0]         q_opcode,
  output logic [WIDTH-1:0]   q_back,
  input  logic [2*WIDTH-1:0] q_top_conc,
  input  logic               q_is_empty,
  input  logic               q_is_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    REDUCE = 2'd1,
    EMIT   = 2'd2,
    ERR    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    Q_PUSH   = 2'b00,
    Q_NOP    = 2'b01,
    Q_REDUCE = 2'b10,
    Q_POP    = 2'b11
  } qop_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            first_q, first_d;
  logic            err_q, err_d;
  qop_t            q_op;
  logic [1:0]      eff_op;
  logic [WIDTH-1:0] reduce_val;

  // All operations wrap modulo 2^WIDTH; sub is front minus second.
  function automatic logic [WIDTH-1:0] alu(input logic [1:0]       op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // State, occupancy, latched opcode and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      op_q    <= '0;
      first_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  // Next-state, queue command and handshake decode. Outputs are forced to
  // their idle values while rst is high so the queue sees NOP during reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    first_d    = first_q;
    err_d      = err_q;
    q_op       = Q_NOP;
    q_back     = '0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    eff_op     = first_q ? alu_op : op_q;
    reduce_val = alu(eff_op, q_top_conc[WIDTH-1:0], q_top_conc[2*WIDTH-1:WIDTH]);

    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          if (cnt_q < DEPTH_C) begin
            in_ready = 1'b1;
            if (in_valid) begin
              q_op   = Q_PUSH;
              q_back = in_data;
              cnt_d  = cnt_q + 1'b1;
              if (first_q) begin
                op_d    = alu_op;
                first_d = 1'b0;
              end
              if (in_last) begin
                state_d = (cnt_q == '0) ? EMIT : REDUCE;
              end
            end
          end else begin
            // Full queue: fold the front pair to free a slot, so long
            // expressions stream through a fixed-depth queue.
            q_op   = Q_REDUCE;
            q_back = reduce_val;
            cnt_d  = cnt_q - 1'b1;
          end
        end
        REDUCE: begin
          q_op   = Q_REDUCE;
          q_back = reduce_val;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q <= TWO_C) begin
            state_d = EMIT;
          end
        end
        EMIT: begin
          out_valid = 1'b1;
          out_data  = q_top_conc[WIDTH-1:0];
          if (out_ready) begin
            q_op    = Q_POP;
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = LOAD;
          end
        end
        ERR: begin
        end
      endcase

      if (q_is_err || (q_is_empty && (state_q == REDUCE || state_q == EMIT))) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end

  assign q_opcode = q_op;
  assign err      = err_q;
  assign busy     = (state_q != LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_queue_reduce_sequencer.sv
// Bench for queue_reduce_sequencer: a behavioural 5-entry calculator queue
// sits behind the DUT; expressions come from a directed table, plus
// hand-written sequences for backpressure, error and mid-expression reset.
module tb_queue_reduce_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        err;
  logic [1:0]  q_opcode;
  logic [7:0]  q_back;
  logic [15:0] q_top_conc;
  logic        q_is_empty;
  logic        q_is_err;
  logic        force_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  queue_reduce_sequencer #(.WIDTH(8), .DEPTH(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .alu_op(alu_op),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err),
    .q_opcode(q_opcode), .q_back(q_back),
    .q_top_conc(q_top_conc), .q_is_empty(q_is_empty), .q_is_err(q_is_err)
  );

  // Behavioural calculator queue: PUSH appends, REDUCE drops the front pair
  // and appends q_back, POP drops the front; misuse sets a sticky error.
  logic [7:0]  qm [5];
  int unsigned qn;
  logic        qerr;

  always @(posedge clk) begin
    logic [7:0]  m [5];
    int unsigned n;
    logic        e;
    m = qm; n = qn; e = qerr;
    if (rst) begin
      n = 0; e = 1'b0;
    end else begin
      case (q_opcode)
        2'b00: if (n == 5) e = 1'b1; else begin m[n] = q_back; n++; end
        2'b10: if (n < 2) e = 1'b1;
               else begin
                 for (int i = 0; i < 3; i++) m[i] = m[i+2];
                 n = n - 2; m[n] = q_back; n++;
               end
        2'b11: if (n == 0) e = 1'b1;
               else begin
                 for (int i = 0; i < 4; i++) m[i] = m[i+1];
                 n--;
               end
        default: ;
      endcase
    end
    qm <= m; qn <= n; qerr <= e;
  end

  assign q_top_conc = {(qn >= 2) ? qm[1] : 8'hFF, (qn >= 1) ? qm[0] : 8'hFF};
  assign q_is_empty = (qn == 0);
  assign q_is_err   = qerr | force_err;

  typedef struct packed {
    logic [1:0]  op_first;
    logic [1:0]  op_rest;
    logic [3:0]  n;
    logic [55:0] vals;      // operand i in vals[8*i +: 8]
    logic [7:0]  exp_data;
    logic [3:0]  exp_lat;   // edges after last accept until out_valid
    logic [3:0]  exp_stall; // cycles in_ready was low while LOAD was full
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input bit hold);
    int unsigned stalls = 0;
    int unsigned lat    = 0;
    alu_op = v.op_first;
    for (int unsigned i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_data  = v.vals[8*i +: 8];
      in_last  = (i == v.n - 1);
      #1;
      while (!in_ready && stalls < 20) begin
        chk("stall_reduce", q_opcode, 2'b10);
        tick();
        #1;
        stalls++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      tick();
      alu_op = v.op_rest;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    while (!out_valid && lat < 20) begin
      tick();
      #1;
      lat++;
    end
    chk("latency", lat, v.exp_lat);
    chk("stalls", stalls, v.exp_stall);
    chk("out_data", out_data, v.exp_data);
    if (!hold) begin
      out_ready = 1'b1;
      #1;
      chk("pop_opcode", q_opcode, 2'b11);
      tick();
      out_ready = 1'b0;
      #1;
      chk("after_pop_valid", out_valid, 0);
      chk("after_pop_busy", busy, 0);
      chk("after_pop_empty", q_is_empty, 1);
      chk("after_pop_err", err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //         op1    oprest n   operands (first in low byte)  result lat stall
    vt[0] = '{2'b00, 2'b00, 4'd3, 56'h07_05_03,             8'h0F, 4'd2, 4'd0};
    vt[1] = '{2'b01, 2'b01, 4'd3, 56'h02_03_0A,             8'hFB, 4'd2, 4'd0};
    vt[2] = '{2'b00, 2'b00, 4'd1, 56'h42,                   8'h42, 4'd0, 4'd0};
    vt[3] = '{2'b00, 2'b00, 4'd7, 56'h07_06_05_04_03_02_01, 8'h1C, 4'd4, 4'd2};
    vt[4] = '{2'b10, 2'b10, 4'd3, 56'h3C_0F_FF,             8'h0C, 4'd2, 4'd0};
    vt[5] = '{2'b11, 2'b11, 4'd2, 56'h5A_A5,                8'hFF, 4'd1, 4'd0};
    vt[6] = '{2'b01, 2'b01, 4'd4, 56'h02_01_04_09,          8'h06, 4'd3, 4'd0};
    vt[7] = '{2'b00, 2'b11, 4'd3, 56'h07_05_03,             8'h0F, 4'd2, 4'd0};

    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
    alu_op = 2'b00; out_ready = 1'b0; force_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_opcode", q_opcode, 2'b01);
    chk("reset_out_valid", out_valid, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_err", err, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_data", out_data, 0);
    chk("idle_opcode", q_opcode, 2'b01);
    chk("idle_q_back", q_back, 0);

    for (int unsigned k = 0; k < 8; k++) begin
      run_vec(vt[k], 1'b0);
      tick();
    end

    // Result held under backpressure; operand input ignored meanwhile.
    run_vec(vt[0], 1'b1);
    in_valid = 1'b1; in_data = 8'h99;
    for (int unsigned c = 0; c < 3; c++) begin
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'h0F);
      chk("bp_opcode", q_opcode, 2'b01);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_pop", q_opcode, 2'b11);
    tick();
    out_ready = 1'b0;
    #1;
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_empty", q_is_empty, 1);
    tick();

    // Queue error in LOAD latches err until reset.
    force_err = 1'b1;
    #1;
    tick();
    force_err = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    #1;
    chk("err_set", err, 1);
    chk("err_in_ready", in_ready, 0);
    chk("err_opcode", q_opcode, 2'b01);
    tick();
    chk("err_sticky", err, 1);
    rst = 1'b1;
    #1;
    chk("err_rst_in_ready", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("err_cleared", err, 0);
    chk("err_cleared_in_ready", in_ready, 1);
    tick();

    // Reset in the middle of an expression discards it.
    in_valid = 1'b1; in_data = 8'h09; in_last = 1'b0; alu_op = 2'b00;
    #1;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_empty", q_is_empty, 1);
    run_vec('{2'b00, 2'b00, 4'd2, 56'h04_04, 8'h08, 4'd1, 4'd0}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
